// File: rtl/qu_scheduler_if.sv
// Purpose: bundles the rename-side insert channel, writeback wakeup, issue output and control of qu_scheduler.
// Latency: none (signal container only).
// Backpressure: in_valid/in_ready on insert, out_valid/out_ready on issue; wakeup and control have no handshake.
//
// Ports carried: flush, schedule_en, in_* (insert), wb_* (wakeup), out_* (issue), count.
// master = the environment (rename, writeback, execute); slave = the scheduler.
interface qu_scheduler_if #(
  parameter int DEPTH           = 8,
  parameter int UOP_WIDTH       = 64,
  parameter int PREG_ADDR_WIDTH = 6
) ();
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic                       flush;
  logic                       schedule_en;

  logic                       in_valid;
  logic                       in_ready;
  logic [UOP_WIDTH-1:0]       in_uop;
  logic [PREG_ADDR_WIDTH-1:0] in_rs1_preg;
  logic [PREG_ADDR_WIDTH-1:0] in_rs2_preg;
  logic                       in_rs1_rdy;
  logic                       in_rs2_rdy;

  logic                       wb_valid;
  logic [PREG_ADDR_WIDTH-1:0] wb_preg;

  logic                       out_valid;
  logic                       out_ready;
  logic [UOP_WIDTH-1:0]       out_uop;
  logic [PREG_ADDR_WIDTH-1:0] out_rs1_preg;
  logic [PREG_ADDR_WIDTH-1:0] out_rs2_preg;

  logic [CNT_W-1:0]           count;

  modport master (
    output flush, schedule_en,
    output in_valid, in_uop, in_rs1_preg, in_rs2_preg, in_rs1_rdy, in_rs2_rdy,
    input  in_ready,
    output wb_valid, wb_preg,
    input  out_valid, out_uop, out_rs1_preg, out_rs2_preg,
    output out_ready,
    input  count
  );

  modport slave (
    input  flush, schedule_en,
    input  in_valid, in_uop, in_rs1_preg, in_rs2_preg, in_rs1_rdy, in_rs2_rdy,
    output in_ready,
    input  wb_valid, wb_preg,
    output out_valid, out_uop, out_rs1_preg, out_rs2_preg,
    input  out_ready,
    output count
  );
endinterface

// File: rtl/qu_scheduler.sv
// Purpose: age-ordered collapsing issue queue with operand wakeup; issues oldest ready uop into an output register.
// Latency: insert of a ready uop at edge k -> out_valid after edge k+1; wakeup at edge k -> issue at edge k+1.
// Backpressure: in_ready = registered count < DEPTH; out_valid && !out_ready freezes the output register.
//
// Ports: clk, rst (async active-low), sif (qu_scheduler_if.slave: flush, schedule_en, insert channel,
// wakeup broadcast, issue channel, count).
module qu_scheduler #(
  parameter int DEPTH           = 8,
  parameter int UOP_WIDTH       = 64,
  parameter int PREG_ADDR_WIDTH = 6
) (
  input  logic          clk,
  input  logic          rst,
  qu_scheduler_if.slave sif
);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  // Queue storage; index 0 is always the oldest valid entry.
  logic [DEPTH-1:0]           vld_q, vld_d;
  logic [DEPTH-1:0]           rdy1_q, rdy1_d;
  logic [DEPTH-1:0]           rdy2_q, rdy2_d;
  logic [UOP_WIDTH-1:0]       uop_q  [DEPTH];
  logic [UOP_WIDTH-1:0]       uop_d  [DEPTH];
  logic [PREG_ADDR_WIDTH-1:0] tag1_q [DEPTH];
  logic [PREG_ADDR_WIDTH-1:0] tag1_d [DEPTH];
  logic [PREG_ADDR_WIDTH-1:0] tag2_q [DEPTH];
  logic [PREG_ADDR_WIDTH-1:0] tag2_d [DEPTH];
  logic [CNT_W-1:0]           count_q, count_d;

  // Output register toward execute.
  logic                       out_vld_q, out_vld_d;
  logic [UOP_WIDTH-1:0]       out_uop_q, out_uop_d;
  logic [PREG_ADDR_WIDTH-1:0] out_rs1_q, out_rs1_d;
  logic [PREG_ADDR_WIDTH-1:0] out_rs2_q, out_rs2_d;

  logic                       in_ready;
  logic [DEPTH-1:0]           elig;
  logic [IDX_W-1:0]           sel_idx;
  logic                       slot_free;
  logic                       issue;
  logic                       push;
  logic [CNT_W-1:0]           ins_idx;
  logic [IDX_W:0]             src;

  // Accept decision uses registered count only, so an issue on the same edge does not free a slot early.
  assign in_ready = (count_q < CNT_W'(DEPTH));

  // Selection: lowest-index eligible entry, using registered ready bits (wakeup never bypasses).
  always_comb begin
    elig    = vld_q & rdy1_q & rdy2_q & {DEPTH{sif.schedule_en}};
    sel_idx = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (elig[i]) sel_idx = IDX_W'(i);
    end
    slot_free = !out_vld_q || sif.out_ready;
    issue     = slot_free && (|elig) && !sif.flush;
    push      = sif.in_valid && in_ready && !sif.flush;
    // With a simultaneous issue the queue collapses first, so the tail moves down by one.
    ins_idx   = count_q - CNT_W'(issue);
  end

  // Entry update: collapse above the issued slot, wake up, then write the new tail entry.
  always_comb begin
    vld_d  = '0;
    rdy1_d = '0;
    rdy2_d = '0;
    src    = '0;
    for (int i = 0; i < DEPTH; i++) begin
      uop_d[i]  = uop_q[i];
      tag1_d[i] = tag1_q[i];
      tag2_d[i] = tag2_q[i];

      if (issue && ((IDX_W + 1)'(i) >= {1'b0, sel_idx})) begin
        src = (IDX_W + 1)'(i + 1);
      end else begin
        src = (IDX_W + 1)'(i);
      end

      if (src < (IDX_W + 1)'(DEPTH)) begin
        vld_d[i]  = vld_q[src[IDX_W-1:0]];
        rdy1_d[i] = rdy1_q[src[IDX_W-1:0]];
        rdy2_d[i] = rdy2_q[src[IDX_W-1:0]];
        uop_d[i]  = uop_q[src[IDX_W-1:0]];
        tag1_d[i] = tag1_q[src[IDX_W-1:0]];
        tag2_d[i] = tag2_q[src[IDX_W-1:0]];
      end else begin
        // Top slot vacated by the collapse.
        vld_d[i]  = 1'b0;
        rdy1_d[i] = 1'b0;
        rdy2_d[i] = 1'b0;
      end

      // Wakeup applies after the shift so moving entries do not miss a broadcast.
      if (sif.wb_valid && vld_d[i]) begin
        if (tag1_d[i] == sif.wb_preg) rdy1_d[i] = 1'b1;
        if (tag2_d[i] == sif.wb_preg) rdy2_d[i] = 1'b1;
      end

      if (push && (CNT_W'(i) == ins_idx)) begin
        vld_d[i]  = 1'b1;
        uop_d[i]  = sif.in_uop;
        tag1_d[i] = sif.in_rs1_preg;
        tag2_d[i] = sif.in_rs2_preg;
        rdy1_d[i] = sif.in_rs1_rdy || (sif.wb_valid && (sif.in_rs1_preg == sif.wb_preg));
        rdy2_d[i] = sif.in_rs2_rdy || (sif.wb_valid && (sif.in_rs2_preg == sif.wb_preg));
      end
    end
    if (sif.flush) vld_d = '0;
  end

  // Occupancy and output register.
  always_comb begin
    count_d   = count_q + CNT_W'(push) - CNT_W'(issue);
    out_vld_d = out_vld_q;
    out_uop_d = out_uop_q;
    out_rs1_d = out_rs1_q;
    out_rs2_d = out_rs2_q;
    if (sif.flush) begin
      count_d   = '0;
      out_vld_d = 1'b0;
    end else if (issue) begin
      out_vld_d = 1'b1;
      out_uop_d = uop_q[sel_idx];
      out_rs1_d = tag1_q[sel_idx];
      out_rs2_d = tag2_q[sel_idx];
    end else if (sif.out_ready) begin
      // Drain without replacement; payload is left as-is.
      out_vld_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_q     <= '0;
      rdy1_q    <= '0;
      rdy2_q    <= '0;
      count_q   <= '0;
      out_vld_q <= 1'b0;
      out_uop_q <= '0;
      out_rs1_q <= '0;
      out_rs2_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        uop_q[i]  <= '0;
        tag1_q[i] <= '0;
        tag2_q[i] <= '0;
      end
    end else begin
      vld_q     <= vld_d;
      rdy1_q    <= rdy1_d;
      rdy2_q    <= rdy2_d;
      count_q   <= count_d;
      out_vld_q <= out_vld_d;
      out_uop_q <= out_uop_d;
      out_rs1_q <= out_rs1_d;
      out_rs2_q <= out_rs2_d;
      for (int i = 0; i < DEPTH; i++) begin
        uop_q[i]  <= uop_d[i];
        tag1_q[i] <= tag1_d[i];
        tag2_q[i] <= tag2_d[i];
      end
    end
  end

  assign sif.in_ready     = in_ready;
  assign sif.out_valid    = out_vld_q;
  assign sif.out_uop      = out_uop_q;
  assign sif.out_rs1_preg = out_rs1_q;
  assign sif.out_rs2_preg = out_rs2_q;
  assign sif.count        = count_q;

endmodule

// File: tb/tb_qu_scheduler.sv
// Purpose: self-checking bench for qu_scheduler: directed vector table, corner sequences, random vs queue model.
// Latency: checks sampled 1 time unit after each rising edge.
// Backpressure: exercises full queue, frozen output and flush/reset during activity.
module tb_qu_scheduler;
  localparam int DEPTH = 8;
  localparam int UW    = 64;
  localparam int PW    = 6;

  logic clk;
  logic rst;

  qu_scheduler_if #(.DEPTH(DEPTH), .UOP_WIDTH(UW), .PREG_ADDR_WIDTH(PW)) sif ();

  qu_scheduler #(.DEPTH(DEPTH), .UOP_WIDTH(UW), .PREG_ADDR_WIDTH(PW)) dut (
    .clk (clk),
    .rst (rst),
    .sif (sif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model: ordered list of waiting uops ----------------
  typedef struct {
    logic [UW-1:0] uop;
    logic [PW-1:0] t1;
    logic [PW-1:0] t2;
    bit            r1;
    bit            r2;
  } ent_t;

  ent_t          mq[$];
  bit            m_ov;
  logic [UW-1:0] m_uop;
  logic [PW-1:0] m_t1, m_t2;

  function automatic void model_reset();
    mq.delete();
    m_ov  = 1'b0;
    m_uop = '0;
    m_t1  = '0;
    m_t2  = '0;
  endfunction

  // Next state from the inputs currently driven, evaluated just before the edge.
  function automatic void model_step();
    bit   accept;
    int   pick;
    ent_t e;
    if (sif.flush) begin
      mq.delete();
      m_ov = 1'b0;
      return;
    end
    accept = sif.in_valid && (mq.size() < DEPTH);
    pick = -1;
    if (sif.schedule_en && (!m_ov || sif.out_ready)) begin
      foreach (mq[i]) begin
        if (pick < 0 && mq[i].r1 && mq[i].r2) pick = i;
      end
    end
    if (pick >= 0) begin
      m_ov  = 1'b1;
      m_uop = mq[pick].uop;
      m_t1  = mq[pick].t1;
      m_t2  = mq[pick].t2;
      mq.delete(pick);
    end else if (sif.out_ready) begin
      m_ov = 1'b0;
    end
    if (sif.wb_valid) begin
      foreach (mq[i]) begin
        if (mq[i].t1 == sif.wb_preg) mq[i].r1 = 1'b1;
        if (mq[i].t2 == sif.wb_preg) mq[i].r2 = 1'b1;
      end
    end
    if (accept) begin
      e.uop = sif.in_uop;
      e.t1  = sif.in_rs1_preg;
      e.t2  = sif.in_rs2_preg;
      e.r1  = sif.in_rs1_rdy || (sif.wb_valid && sif.in_rs1_preg == sif.wb_preg);
      e.r2  = sif.in_rs2_rdy || (sif.wb_valid && sif.in_rs2_preg == sif.wb_preg);
      mq.push_back(e);
    end
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic idle();
    sif.flush       = 1'b0;
    sif.schedule_en = 1'b1;
    sif.in_valid    = 1'b0;
    sif.in_uop      = '0;
    sif.in_rs1_preg = '0;
    sif.in_rs2_preg = '0;
    sif.in_rs1_rdy  = 1'b1;
    sif.in_rs2_rdy  = 1'b1;
    sif.wb_valid    = 1'b0;
    sif.wb_preg     = '0;
    sif.out_ready   = 1'b1;
  endtask

  task automatic put(logic [UW-1:0] u, logic [PW-1:0] t1, bit r1, logic [PW-1:0] t2, bit r2);
    sif.in_valid    = 1'b1;
    sif.in_uop      = u;
    sif.in_rs1_preg = t1;
    sif.in_rs1_rdy  = r1;
    sif.in_rs2_preg = t2;
    sif.in_rs2_rdy  = r2;
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    check("mdl_count",    64'(sif.count), 64'(mq.size()));
    check("mdl_in_ready", 64'(sif.in_ready), 64'(mq.size() < DEPTH));
    check("mdl_out_valid", 64'(sif.out_valid), 64'(m_ov));
    check("mdl_out_uop",  sif.out_uop, m_uop);
    check("mdl_out_rs1",  64'(sif.out_rs1_preg), 64'(m_t1));
    check("mdl_out_rs2",  64'(sif.out_rs2_preg), 64'(m_t2));
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    bit            se;
    bit            iv;
    logic [7:0]    uop;
    logic [PW-1:0] t1;
    bit            r1;
    bit            wv;
    logic [PW-1:0] wp;
    int            ecnt;
    bit            eov;
    logic [7:0]    euop;
  } vec_t;

  function automatic vec_t mk(bit se, bit iv, logic [7:0] uop, logic [PW-1:0] t1, bit r1,
                              bit wv, logic [PW-1:0] wp, int ecnt, bit eov, logic [7:0] euop);
    vec_t v;
    v.se = se; v.iv = iv; v.uop = uop; v.t1 = t1; v.r1 = r1;
    v.wv = wv; v.wp = wp; v.ecnt = ecnt; v.eov = eov; v.euop = euop;
    return v;
  endfunction

  vec_t vecs[$];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    // basic issue
    vecs.push_back(mk(1, 1, 8'hA1, 0, 1, 0, 0, 1, 0, 8'h00));
    vecs.push_back(mk(1, 0, 8'h00, 0, 1, 0, 0, 0, 1, 8'hA1));
    vecs.push_back(mk(1, 0, 8'h00, 0, 1, 0, 0, 0, 0, 8'hA1));
    // wakeup ordering: B0 waits on tag 5, B1 overtakes it
    vecs.push_back(mk(1, 1, 8'hB0, 5, 0, 0, 0, 1, 0, 8'hA1));
    vecs.push_back(mk(1, 1, 8'hB1, 1, 1, 0, 0, 2, 0, 8'hA1));
    vecs.push_back(mk(1, 0, 8'h00, 0, 1, 0, 0, 1, 1, 8'hB1));
    vecs.push_back(mk(1, 0, 8'h00, 0, 1, 1, 5, 1, 0, 8'hB1));
    vecs.push_back(mk(1, 0, 8'h00, 0, 1, 0, 0, 0, 1, 8'hB0));
    vecs.push_back(mk(1, 0, 8'h00, 0, 1, 0, 0, 0, 0, 8'hB0));
    // age order
    vecs.push_back(mk(0, 1, 8'h10, 0, 1, 0, 0, 1, 0, 8'hB0));
    vecs.push_back(mk(0, 1, 8'h11, 0, 1, 0, 0, 2, 0, 8'hB0));
    vecs.push_back(mk(0, 1, 8'h12, 0, 1, 0, 0, 3, 0, 8'hB0));
    vecs.push_back(mk(1, 0, 8'h00, 0, 1, 0, 0, 2, 1, 8'h10));
    vecs.push_back(mk(1, 0, 8'h00, 0, 1, 0, 0, 1, 1, 8'h11));
    vecs.push_back(mk(1, 0, 8'h00, 0, 1, 0, 0, 0, 1, 8'h12));
    vecs.push_back(mk(1, 0, 8'h00, 0, 1, 0, 0, 0, 0, 8'h12));

    // reset
    rst = 1'b0;
    idle();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    model_reset();
    check("rst_count", 64'(sif.count), 64'd0);
    check("rst_in_ready", 64'(sif.in_ready), 64'd1);
    check("rst_out_valid", 64'(sif.out_valid), 64'd0);
    check("rst_out_uop", sif.out_uop, 64'd0);

    foreach (vecs[k]) begin
      v = vecs[k];
      idle();
      sif.schedule_en = v.se;
      if (v.iv) put(64'(v.uop), v.t1, v.r1, '0, 1'b1);
      sif.wb_valid = v.wv;
      sif.wb_preg  = v.wp;
      tick();
      check($sformatf("vec%0d_count", k), 64'(sif.count), 64'(v.ecnt));
      check($sformatf("vec%0d_in_ready", k), 64'(sif.in_ready), 64'd1);
      check($sformatf("vec%0d_out_valid", k), 64'(sif.out_valid), 64'(v.eov));
      check($sformatf("vec%0d_out_uop", k), sif.out_uop, 64'(v.euop));
    end

    // full queue
    for (int i = 0; i < DEPTH; i++) begin
      idle();
      sif.schedule_en = 1'b0;
      put(64'(8'h20 + i), 0, 1, 0, 1);
      tick();
      check("full_fill_count", 64'(sif.count), 64'(i + 1));
    end
    check("full_in_ready", 64'(sif.in_ready), 64'd0);
    idle();
    sif.schedule_en = 1'b0;
    put(64'h28, 0, 1, 0, 1);
    tick();
    check("full_reject_count", 64'(sif.count), 64'd8);
    idle();
    put(64'h29, 0, 1, 0, 1);
    tick();
    check("full_issue_count", 64'(sif.count), 64'd7);
    check("full_issue_in_ready", 64'(sif.in_ready), 64'd1);
    check("full_issue_uop", sif.out_uop, 64'h20);
    idle();
    repeat (9) tick();
    check("full_drain_count", 64'(sif.count), 64'd0);
    check("full_drain_ov", 64'(sif.out_valid), 64'd0);

    // back-pressure
    for (int i = 0; i < 3; i++) begin
      idle();
      sif.schedule_en = 1'b0;
      sif.out_ready   = 1'b0;
      put(64'(8'h30 + i), 0, 1, 0, 1);
      tick();
    end
    idle();
    sif.out_ready = 1'b0;
    tick();
    check("bp_first_uop", sif.out_uop, 64'h30);
    tick();
    check("bp_hold_ov", 64'(sif.out_valid), 64'd1);
    check("bp_hold_uop", sif.out_uop, 64'h30);
    check("bp_hold_count", 64'(sif.count), 64'd2);
    sif.out_ready = 1'b1;
    tick();
    check("bp_rel1_uop", sif.out_uop, 64'h31);
    tick();
    check("bp_rel2_uop", sif.out_uop, 64'h32);
    check("bp_rel2_ov", 64'(sif.out_valid), 64'd1);
    tick();
    check("bp_end_ov", 64'(sif.out_valid), 64'd0);

    // flush with 4 queued entries and a held output
    for (int i = 0; i < 5; i++) begin
      idle();
      sif.schedule_en = 1'b0;
      put(64'(8'h40 + i), 0, 1, 0, 1);
      tick();
    end
    idle();
    sif.out_ready = 1'b0;
    tick();
    check("fl_pre_count", 64'(sif.count), 64'd4);
    check("fl_pre_ov", 64'(sif.out_valid), 64'd1);
    idle();
    sif.out_ready = 1'b0;
    sif.flush     = 1'b1;
    put(64'h50, 0, 1, 0, 1);
    tick();
    check("fl_count", 64'(sif.count), 64'd0);
    check("fl_ov", 64'(sif.out_valid), 64'd0);
    idle();
    tick();
    check("fl_after_count", 64'(sif.count), 64'd0);

    // asynchronous reset between edges
    for (int i = 0; i < 2; i++) begin
      idle();
      sif.schedule_en = 1'b0;
      put(64'(8'h60 + i), 0, 1, 0, 1);
      tick();
    end
    idle();
    sif.out_ready = 1'b0;
    tick();
    check("ar_pre_count", 64'(sif.count), 64'd1);
    check("ar_pre_ov", 64'(sif.out_valid), 64'd1);
    #2;
    rst = 1'b0;
    model_reset();
    #1;
    check("ar_count", 64'(sif.count), 64'd0);
    check("ar_ov", 64'(sif.out_valid), 64'd0);
    check("ar_uop", sif.out_uop, 64'd0);
    @(negedge clk);
    rst = 1'b1;
    check("ar_in_ready", 64'(sif.in_ready), 64'd1);

    // randomized traffic against the model
    for (int n = 0; n < 2000; n++) begin
      sif.flush       = ($urandom_range(0, 49) == 0);
      sif.schedule_en = ($urandom_range(0, 3) != 0);
      sif.in_valid    = $urandom_range(0, 1);
      sif.in_uop      = {$urandom(), $urandom()};
      sif.in_rs1_preg = PW'($urandom_range(0, 7));
      sif.in_rs2_preg = PW'($urandom_range(0, 7));
      sif.in_rs1_rdy  = $urandom_range(0, 1);
      sif.in_rs2_rdy  = $urandom_range(0, 1);
      sif.wb_valid    = ($urandom_range(0, 2) == 0);
      sif.wb_preg     = PW'($urandom_range(0, 7));
      sif.out_ready   = ($urandom_range(0, 3) != 0);
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/qu_scheduler.md
# qu_scheduler

Issue queue sitting directly downstream of the rename (RN) stage in `qu_core`. It buffers renamed micro-ops and tracks source-operand readiness through a writeback wakeup broadcast. When `schedule_en` is high, it issues the oldest ready micro-op into a registered output toward execute. Entries are kept age-ordered in a collapsing queue: index 0 is always the oldest.

## Interface
- `DEPTH`, 8: queue entries (≥2).
- `UOP_WIDTH`, 64: opaque micro-op payload width.
- `PREG_ADDR_WIDTH`, 6: physical register tag width.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `flush`  in  1  synchronous clear of queue and output register.
- `schedule_en`  in  1  issue enable.
- `in_valid`  in  1  RN offers a micro-op.
- `in_ready`  out  1  queue can accept a micro-op.
- `in_uop`  in  UOP_WIDTH  payload.
- `in_rs1_preg`, `in_rs2_preg`  in  PREG_ADDR_WIDTH  source tags.
- `in_rs1_rdy`, `in_rs2_rdy`  in  1  source already available (set to 1 when the source is unused).
- `wb_valid`  in  1  wakeup broadcast valid.
- `wb_preg`  in  PREG_ADDR_WIDTH  tag being written back.
- `out_valid`  out  1  issued micro-op present.
- `out_ready`  in  1  execute accepts the output.
- `out_uop`  out  UOP_WIDTH  issued payload.
- `out_rs1_preg`, `out_rs2_preg`  out  PREG_ADDR_WIDTH  issued source tags.
- `count`  out  $clog2(DEPTH+1)  occupied entries.

## Operation
- **Entry contents:** valid, uop, rs1/rs2 tag, rs1/rs2 ready bit.
- **Entry eligibility:** an entry is eligible when valid, both ready bits are 1, and `schedule_en` is 1.
- **Accept:** `in_ready = (count < DEPTH)`, taken from registered `count` only; an issue in the same cycle does not raise it. A handshake (`in_valid && in_ready`) writes the entry at the tail.
- **Issue slot free:** `!out_valid || out_ready`. When the slot is free and an entry is eligible, the lowest-index eligible entry moves into the output register. Entries above it shift down by one in the same edge.
- **Simultaneous insert and issue:** the new entry lands at index `count-1`. `count` stays unchanged.
- **Wakeup on stored entries:** when `wb_valid` is high, every valid entry whose rs1 or rs2 tag equals `wb_preg` sets that ready bit. This also applies to entries shifting in that edge.
- **Wakeup on insert:** an entry inserted in the same cycle as a matching `wb_valid` is stored with that ready bit set.
- **Wakeup does not bypass:** wakeup never makes an entry eligible in the same cycle. Selection uses the registered ready bits.
- **Output drain:** `out_ready && out_valid` with no new issue clears `out_valid`. The output payload holds its value otherwise.
- **`schedule_en` low:** no selection takes place. Insert, wakeup and output drain continue normally.
- **`flush`:** all entry valids, `count` and `out_valid` go to 0 on the next edge. The input handshake is ignored that cycle. `flush` has priority over every other event.
- **Arithmetic:** `count` never wraps and saturates logically at DEPTH. Tag compare is full-width equality.
- **Reset (`rst` low, asynchronous):**
  - entry valids and ready bits = 0
  - `count` = 0
  - `out_valid` = 0
  - `out_uop`, `out_rs1_preg`, `out_rs2_preg` = 0
  - `in_ready` = 1 once reset is released
  - Reset mid-operation discards all contents.

## Timing
- **Minimum latency:** handshake at edge k with both sources ready → selectable at edge k+1 → `out_valid` = 1 after edge k+1.
- **Wakeup latency:** wakeup at edge k → entry selectable at edge k+1 → `out_valid` after edge k+1.
- **Throughput:** one issue per cycle with `out_ready` held high. One insert per cycle while not full.
- **Full queue:** `in_ready` is 0 for the whole cycle in which `count == DEPTH`, even if an issue occurs on that edge. It rises the cycle after.
- **Output back-pressure:** `out_valid && !out_ready` freezes the output register. The queue still accepts inserts and wakeups while the output is frozen.

## Test plan
- **Reset and basic issue:**
  - Stimulus: after reset, `schedule_en`=1, `out_ready`=1; insert uop `0xA1` with both rdy=1.
  - Required: `count`=1 for one cycle; `out_valid`=1 with `out_uop`=`0xA1` the cycle after insert; `count` returns to 0.
- **Wakeup ordering:**
  - Stimulus: insert `0xB0` with rs1 tag 5 not ready, then `0xB1` fully ready.
  - Required: `0xB1` issues first. Then pulse `wb_preg`=5. `0xB0` issues exactly one cycle after the wakeup edge.
- **Age order:**
  - Stimulus: `schedule_en`=0; insert `0x10`, `0x11`, `0x12`, all ready; then raise `schedule_en`.
  - Required: issue order `0x10`, `0x11`, `0x12` on consecutive cycles.
- **Full queue:**
  - Stimulus: `schedule_en`=0; insert 8 ready uops.
  - Required: `count`=8 and `in_ready`=0. A 9th `in_valid` is not accepted. Enabling issue drops `count` to 7 and `in_ready` returns to 1 the following cycle.
- **Back-pressure:**
  - Stimulus: `out_ready`=0 with 3 ready entries.
  - Required: `out_valid` stays 1 with the first uop held and `count`=2. Releasing `out_ready` yields the remaining two on consecutive cycles.
- **Flush and async reset:**
  - Stimulus: `flush` with 4 entries and `out_valid`=1; separately, assert `rst` low mid-stream between edges.
  - Required: after `flush`, `count`=0 and `out_valid`=0 on the next edge. After the `rst` assertion, `count` and `out_valid` go to 0 immediately, without waiting for a clock edge.
